// File: rtl/thinning_pass_controller.sv
// Thinning pass sequencer: streams the image into kernelRam, drains results
// back to the image RAM and repeats passes until nothing changes.
module thinning_pass_controller #(
    parameter int N          = 8,
    parameter int bitSize    = 6,
    parameter int pixelWidth = 8,
    parameter int STEP       = 2,
    parameter int MAX_PASSES = 15,
    parameter int CNT_W      = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic [3:0]            pass_count,
    output logic [CNT_W-1:0]      change_count,
    output logic [CNT_W-1:0]      harris_count,
    output logic [bitSize:0]      img_addr,
    input  logic [pixelWidth-1:0] img_rd_data,
    output logic                  img_wr_en,
    output logic [pixelWidth-1:0] img_wr_data,
    output logic                  kr_we,
    output logic [bitSize:0]      kr_addr,
    output logic [pixelWidth-1:0] kr_data,
    input  logic [pixelWidth-1:0] result_pixel,
    input  logic                  result_harris
);

    localparam int AW = bitSize + 1;
    localparam int SW = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [AW-1:0] LAST_A = AW'(N * N - 1);
    localparam logic [SW-1:0] LAST_S = SW'(STEP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [4:0] MAX_P = 5'(MAX_PASSES);

    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_LOAD, S_GAP, S_DRAIN, S_CHECK, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [SW-1:0]         sub_q, sub_d;
    logic [pixelWidth-1:0] pix_q, pix_d;
    logic [CNT_W-1:0]      chg_q, chg_d;
    logic [CNT_W-1:0]      har_q, har_d;
    logic [3:0]            pass_q, pass_d;
    logic                  conv_q, conv_d;
    logic                  slot_last;
    logic                  addr_last;
    logic [4:0]            pass_inc;

    assign slot_last = (sub_q == LAST_S);
    assign addr_last = (addr_q == LAST_A);
    assign pass_inc  = {1'b0, pass_q} + 5'd1;

    // Next-state and counter update for the pass sequencer
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sub_d   = sub_q;
        pix_d   = pix_q;
        chg_d   = chg_q;
        har_d   = har_q;
        pass_d  = pass_q;
        conv_d  = conv_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_PRIME;
                    addr_d  = '0;
                    sub_d   = '0;
                    chg_d   = '0;
                    har_d   = '0;
                    pass_d  = '0;
                    conv_d  = 1'b0;
                end
            end
            S_PRIME: begin
                chg_d   = '0;
                har_d   = '0;
                pix_d   = img_rd_data;
                addr_d  = '0;
                sub_d   = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                sub_d = slot_last ? '0 : sub_q + 1'b1;
                if (slot_last) begin
                    pix_d = img_rd_data;
                    if (addr_last) begin
                        addr_d  = '0;
                        state_d = S_GAP;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                sub_d = slot_last ? '0 : sub_q + 1'b1;
                if (slot_last) begin
                    addr_d  = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                sub_d = slot_last ? '0 : sub_q + 1'b1;
                if (slot_last) begin
                    if (result_pixel != img_rd_data && chg_q != CNT_MAX)
                        chg_d = chg_q + 1'b1;
                    if (result_harris && har_q != CNT_MAX)
                        har_d = har_q + 1'b1;
                    if (addr_last) begin
                        addr_d  = '0;
                        state_d = S_CHECK;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_CHECK: begin
                pass_d = pass_inc[3:0];
                if (chg_q == '0) begin
                    conv_d  = 1'b1;
                    state_d = S_DONE;
                end else if (pass_inc == MAX_P) begin
                    conv_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_PRIME;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            sub_q   <= '0;
            pix_q   <= '0;
            chg_q   <= '0;
            har_q   <= '0;
            pass_q  <= '0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sub_q   <= sub_d;
            pix_q   <= pix_d;
            chg_q   <= chg_d;
            har_q   <= har_d;
            pass_q  <= pass_d;
            conv_q  <= conv_d;
        end
    end

    // Port decode; the write strobe is squashed while reset is asserted
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        img_addr     = '0;
        img_wr_en    = 1'b0;
        img_wr_data  = '0;
        kr_we        = 1'b0;
        kr_addr      = '0;
        kr_data      = '0;
        converged    = conv_q;
        pass_count   = pass_q;
        change_count = chg_q;
        harris_count = har_q;
        case (state_q)
            S_PRIME, S_GAP, S_CHECK: busy = 1'b1;
            S_LOAD: begin
                busy     = 1'b1;
                kr_we    = 1'b1;
                kr_addr  = addr_q;
                kr_data  = pix_q;
                img_addr = addr_last ? '0 : addr_q + 1'b1;
            end
            S_DRAIN: begin
                busy     = 1'b1;
                kr_addr  = addr_q;
                img_addr = addr_q;
                if (slot_last && !rst) begin
                    img_wr_en   = 1'b1;
                    img_wr_data = result_pixel;
                end
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule
